// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register bank: FSM states, address decode and ID defaults.
package apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWait,
        StDone
    } apb_state_e;

    localparam int unsigned APB_ADDR_LSB     = 2;
    localparam int unsigned ID_REG_IDX       = 0;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA2B0_0001;

    // Error-cause encoding for anything that wants to classify a pslverr response.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_ALIGN    = 2'd2;
    localparam logic [1:0] ERR_RO_WRITE = 2'd3;

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable 4-bit down counter that times the wait states of one APB access phase.
module apb_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       last
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // While loading, a stale count left by an aborted transfer must not be mistaken for "last".
    assign last = load ? (load_val == 4'd0) : (count_q == 4'd1);

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer with REG_NUM word registers (index 0 = read-only ID) and WAIT_STATES wait cycles.
// Optional byte strobes are enabled by defining APB_PSTRB_EN.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_NUM     = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
`endif
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o
);

    localparam int unsigned IdxW     = $clog2(REG_NUM);
    localparam int unsigned IdxHi    = APB_ADDR_LSB + IdxW;
    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    apb_state_e            state_q, state_d, state_cur;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
    logic [DATA_WIDTH-1:0] regs_d [REG_NUM];
    logic [NumBytes-1:0]   wr_strb;
    logic [IdxW-1:0]       idx;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err_range, err_align, err_ro, err_strb, err;
    logic                  cnt_load, cnt_en, cnt_last, pready;

`ifdef APB_PSTRB_EN
    logic [NumBytes-1:0] pstrb_q, pstrb_d;
    assign wr_strb  = pstrb_q;
    assign err_strb = !pwrite_q && (|pstrb_q);
`else
    assign wr_strb  = '1;
    assign err_strb = 1'b0;
`endif

    assign idx       = paddr_q[IdxHi-1:APB_ADDR_LSB];
    assign err_range = |paddr_q[ADDR_WIDTH-1:IdxHi];
    assign err_align = |paddr_q[APB_ADDR_LSB-1:0];
    assign err_ro    = pwrite_q && (idx == IdxW'(ID_REG_IDX));
    assign err       = err_range | err_align | err_ro | err_strb;
    assign rdata     = (idx == IdxW'(ID_REG_IDX)) ? ID_VALUE : regs_q[idx];

    apb_wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (4'(WAIT_STATES)),
        .en       (cnt_en),
        .last     (cnt_last)
    );

    always_comb begin
        // SETUP is the APB setup-phase cycle itself, decoded out of IDLE, so that the first
        // access cycle is already WAIT or DONE and WAIT_STATES=0 gives a 2-cycle transfer.
        state_cur = state_q;
        if ((state_q == StIdle) && psel_i && !penable_i) begin
            state_cur = StSetup;
        end

        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
`ifdef APB_PSTRB_EN
        pstrb_d  = pstrb_q;
`endif
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        pready   = 1'b0;

        case (state_cur)
            StIdle: begin
                state_d = StIdle;
            end
            StSetup: begin
                paddr_d  = paddr_i;
                pwrite_d = pwrite_i;
                pwdata_d = pwdata_i;
`ifdef APB_PSTRB_EN
                pstrb_d  = pstrb_i;
`endif
                cnt_load = 1'b1;
                state_d  = cnt_last ? StDone : StWait;
            end
            StWait: begin
                if (!psel_i) begin
                    state_d = StIdle;
                end else if (penable_i) begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                pready  = psel_i && penable_i;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (pready && pwrite_q && !err) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (wr_strb[b]) begin
                    regs_d[idx][8*b +: 8] = pwdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
`ifdef APB_PSTRB_EN
            pstrb_q  <= '0;
`endif
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
`ifdef APB_PSTRB_EN
            pstrb_q  <= pstrb_d;
`endif
            regs_q   <= regs_d;
        end
    end

    assign pready_o  = pready;
    assign pslverr_o = pready && err;
    assign prdata_o  = (pready && !pwrite_q && !err) ? rdata : '0;

endmodule
